// File: rtl/joystick_input_if.sv
// Byte-wide CPU read port for the joystick block: register select and strobe in,
// registered read data and the pending-press indicator out.
interface joystick_input_if;
    logic [1:0] address;
    logic       read_strobe;
    logic [7:0] data_out;
    logic       event_pending;

    modport master (output address, read_strobe, input data_out, event_pending);
    modport slave  (input address, read_strobe, output data_out, event_pending);
endinterface

// File: rtl/joystick_input.sv
// Joystick/button conditioning: per-line 2-flop sync and debounce, sticky
// press/release flags with clear-on-read, presented on a small register port.
module joystick_lane #(
    parameter int DEBOUNCE_CYCLES = 54000,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic stable,
    output logic rise,
    output logic fall
);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [1:0]             sync;
    logic [COUNT_WIDTH-1:0] cnt;
    logic                   accept;

    // accept fires on the edge where stable takes the new level, so the
    // flag stage sees the transition on the same edge
    assign accept = (sync[1] != stable) && (cnt == CNT_MAX);
    assign rise   = accept &  sync[1];
    assign fall   = accept & ~sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[0], ~raw_n};
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + COUNT_WIDTH'(1);
            end
        end
    end
endmodule

module joystick_input #(
    parameter int DEBOUNCE_CYCLES = 54000,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic joystick_0,
    input  logic joystick_1,
    input  logic joystick_2,
    input  logic joystick_3,
    input  logic joystick_4,
    input  logic button_select,
    input  logic button_0,
    joystick_input_if.slave bus
);
    localparam int         NUM_LANES = 7;
    localparam logic [7:0] ID_VALUE  = 8'h4A;

    logic [NUM_LANES-1:0] raw_n;
    logic [NUM_LANES-1:0] stable;
    logic [NUM_LANES-1:0] rise;
    logic [NUM_LANES-1:0] fall;
    logic [NUM_LANES-1:0] press_flags;
    logic [NUM_LANES-1:0] release_flags;
    logic [7:0]           data_q;
    logic                 rd_press;
    logic                 rd_release;

    assign raw_n = {button_0, button_select, joystick_4, joystick_3,
                    joystick_2, joystick_1, joystick_0};

    joystick_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .COUNT_WIDTH    (COUNT_WIDTH)
    ) u_lane [NUM_LANES-1:0] (
        .clk   (clk),
        .reset (reset),
        .raw_n (raw_n),
        .stable(stable),
        .rise  (rise),
        .fall  (fall)
    );

    assign rd_press   = bus.read_strobe && (bus.address == 2'd1);
    assign rd_release = bus.read_strobe && (bus.address == 2'd2);

    // clear happens before OR-ing in new events, so a same-edge event survives
    // the read that misses it
    always_ff @(posedge clk) begin
        if (reset) begin
            press_flags   <= '0;
            release_flags <= '0;
            data_q        <= '0;
        end else begin
            press_flags   <= (rd_press   ? '0 : press_flags)   | rise;
            release_flags <= (rd_release ? '0 : release_flags) | fall;
            if (bus.read_strobe) begin
                case (bus.address)
                    2'd0:    data_q <= {1'b0, stable};
                    2'd1:    data_q <= {1'b0, press_flags};
                    2'd2:    data_q <= {1'b0, release_flags};
                    default: data_q <= ID_VALUE;
                endcase
            end
        end
    end

    assign bus.data_out      = data_q;
    assign bus.event_pending = |press_flags;
endmodule

// File: tb/tb_joystick_input.sv
// Directed bench for joystick_input with a 4-cycle debounce window.
module tb_joystick_input;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic joystick_0 = 1'b1, joystick_1 = 1'b1, joystick_2 = 1'b1;
    logic joystick_3 = 1'b1, joystick_4 = 1'b1;
    logic button_select = 1'b1, button_0 = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] rd;

    joystick_input_if bus ();

    joystick_input #(.DEBOUNCE_CYCLES(4), .COUNT_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .joystick_0   (joystick_0),
        .joystick_1   (joystick_1),
        .joystick_2   (joystick_2),
        .joystick_3   (joystick_3),
        .joystick_4   (joystick_4),
        .button_select(button_select),
        .button_0     (button_0),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [1:0] addr, output logic [7:0] val);
        bus.address     = addr;
        bus.read_strobe = 1'b1;
        tick();
        bus.read_strobe = 1'b0;
        val = bus.data_out;
    endtask

    initial begin
        bus.address     = 2'd0;
        bus.read_strobe = 1'b0;

        // reset state and ID
        tick(3);
        reset = 1'b0;
        chk("rst_data", bus.data_out, 8'h00);
        chk("rst_pend", {7'b0, bus.event_pending}, 8'h00);
        do_read(2'd3, rd); chk("id", rd, 8'h4A);
        do_read(2'd0, rd); chk("rst_a0", rd, 8'h00);
        do_read(2'd1, rd); chk("rst_a1", rd, 8'h00);
        do_read(2'd2, rd); chk("rst_a2", rd, 8'h00);
        chk("rst_pend2", {7'b0, bus.event_pending}, 8'h00);

        // joystick_2 press, exact latency via continuous address-0 reads
        joystick_2      = 1'b0;
        bus.address     = 2'd0;
        bus.read_strobe = 1'b1;
        tick(5);
        chk("j2_pend_early", {7'b0, bus.event_pending}, 8'h00);
        tick();
        chk("j2_pend_set", {7'b0, bus.event_pending}, 8'h01);
        chk("j2_a0_prev", bus.data_out, 8'h00);
        tick();
        chk("j2_a0", bus.data_out, 8'h04);
        bus.read_strobe = 1'b0;
        do_read(2'd1, rd); chk("j2_press", rd, 8'h04);
        chk("j2_pend_clr", {7'b0, bus.event_pending}, 8'h00);
        do_read(2'd1, rd); chk("j2_press2", rd, 8'h00);
        joystick_2 = 1'b1;
        tick(10);
        do_read(2'd2, rd); chk("j2_release", rd, 8'h04);
        do_read(2'd1, rd); chk("j2_no_press", rd, 8'h00);

        // 3-cycle glitch on button_0 must be rejected
        button_0        = 1'b0;
        bus.address     = 2'd0;
        bus.read_strobe = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) button_0 = 1'b1;
            tick();
            chk("glitch_a0", bus.data_out, 8'h00);
        end
        bus.read_strobe = 1'b0;
        do_read(2'd1, rd); chk("glitch_press", rd, 8'h00);
        do_read(2'd2, rd); chk("glitch_rel", rd, 8'h00);

        // simultaneous joystick_0 + button_select
        joystick_0    = 1'b0;
        button_select = 1'b0;
        tick(20);
        do_read(2'd0, rd); chk("dual_a0", rd, 8'h21);
        joystick_0    = 1'b1;
        button_select = 1'b1;
        tick(10);
        do_read(2'd1, rd); chk("dual_press", rd, 8'h21);
        do_read(2'd2, rd); chk("dual_rel", rd, 8'h21);
        do_read(2'd0, rd); chk("dual_a0_off", rd, 8'h00);

        // joystick_4 flag sets on the same edge as a press-flag read
        joystick_4 = 1'b0;
        tick(5);
        do_read(2'd1, rd); chk("race_read", rd, 8'h00);
        chk("race_pend", {7'b0, bus.event_pending}, 8'h01);
        do_read(2'd1, rd); chk("race_next", rd, 8'h10);
        joystick_4 = 1'b1;
        tick(10);
        do_read(2'd2, rd); chk("race_rel", rd, 8'h10);

        // reset mid-debounce clears flags and discards partial count
        joystick_3 = 1'b0;
        tick(10);
        chk("pre_rst_pend", {7'b0, bus.event_pending}, 8'h01);
        do_read(2'd3, rd); chk("pre_rst_id", rd, 8'h4A);
        joystick_1 = 1'b0;
        tick(3);
        joystick_3 = 1'b1;
        reset      = 1'b1;
        tick(2);
        chk("mid_rst_pend", {7'b0, bus.event_pending}, 8'h00);
        chk("mid_rst_data", bus.data_out, 8'h00);
        reset = 1'b0;
        tick(5);
        chk("post_rst_early", {7'b0, bus.event_pending}, 8'h00);
        tick();
        chk("post_rst_pend", {7'b0, bus.event_pending}, 8'h01);
        do_read(2'd1, rd); chk("post_rst_press", rd, 8'h02);
        do_read(2'd0, rd); chk("post_rst_a0", rd, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
